// File: rtl/fc_input_sequencer.sv
// fc_input_sequencer: streams a flattened frame to the FC MAC, one neuron pass at a time.
// The output register is one beat deep and refills on the cycle it empties or hands off.
module fc_input_sequencer #(
    parameter int NUM_ELEMS   = 225,
    parameter int NUM_NEURONS = 10,
    parameter int DATA_W      = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_buffer_full,
    output logic [7:0]               o_rd_addr,
    input  logic signed [DATA_W-1:0] i_rd_data,
    output logic                     o_mac_valid,
    input  logic                     i_mac_ready,
    output logic signed [DATA_W-1:0] o_mac_data,
    output logic [11:0]              o_w_addr,
    output logic                     o_mac_first,
    output logic                     o_mac_last,
    output logic [3:0]               o_neuron_idx,
    input  logic                     i_acc_done,
    input  logic                     i_abort,
    output logic                     o_buf_release,
    output logic                     o_busy,
    output logic                     o_frame_done
);
    typedef enum logic [1:0] {IDLE, STREAM, WAIT_ACC, RELEASE} state_t;
    localparam logic [7:0]  ELEMS  = 8'(NUM_ELEMS);
    localparam logic [7:0]  E_LAST = 8'(NUM_ELEMS - 1);
    localparam logic [3:0]  N_LAST = 4'(NUM_NEURONS - 1);
    localparam logic [11:0] ELEMS12 = 12'(NUM_ELEMS);

    state_t                    state_q, state_d;
    logic [7:0]                elem_q, elem_d;
    logic [3:0]                neuron_q, neuron_d, nidx_q, nidx_d;
    logic                      valid_q, valid_d, first_q, first_d, last_q, last_d;
    logic signed [DATA_W-1:0]  data_q, data_d;
    logic [11:0]               w_addr_q, w_addr_d;
    logic                      load;

    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        neuron_d = neuron_q;
        valid_d  = valid_q;
        data_d   = data_q;
        w_addr_d = w_addr_q;
        first_d  = first_q;
        last_d   = last_q;
        nidx_d   = nidx_q;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                load    = i_buffer_full;
                state_d = i_buffer_full ? STREAM : IDLE;
            end
            STREAM: begin
                if (!valid_q || i_mac_ready) begin
                    load    = elem_q < ELEMS;
                    valid_d = elem_q < ELEMS;
                end
                if (valid_q && i_mac_ready && last_q) state_d = WAIT_ACC;
            end
            WAIT_ACC: begin
                if (i_acc_done) begin
                    state_d  = (neuron_q == N_LAST) ? RELEASE : STREAM;
                    neuron_d = (neuron_q == N_LAST) ? neuron_q : neuron_q + 4'd1;
                    elem_d   = 8'd0;
                end
            end
            RELEASE: begin
                state_d  = IDLE;
                elem_d   = 8'd0;
                neuron_d = 4'd0;
            end
        endcase
        // element counter is the fetch pointer: it moves whenever a beat enters the output register
        if (load) begin
            data_d   = i_rd_data;
            w_addr_d = 12'(neuron_q) * ELEMS12 + 12'(elem_q);
            first_d  = elem_q == 8'd0;
            last_d   = elem_q == E_LAST;
            nidx_d   = neuron_q;
            elem_d   = elem_q + 8'd1;
            valid_d  = 1'b1;
        end
        if (i_abort && state_q != IDLE) begin
            state_d = RELEASE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            elem_q   <= '0;
            neuron_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            w_addr_q <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            nidx_q   <= '0;
        end else begin
            state_q  <= state_d;
            elem_q   <= elem_d;
            neuron_q <= neuron_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            w_addr_q <= w_addr_d;
            first_q  <= first_d;
            last_q   <= last_d;
            nidx_q   <= nidx_d;
        end
    end

    assign o_rd_addr     = elem_q;
    assign o_mac_valid   = valid_q;
    assign o_mac_data    = data_q;
    assign o_w_addr      = w_addr_q;
    assign o_mac_first   = first_q;
    assign o_mac_last    = last_q;
    assign o_neuron_idx  = nidx_q;
    assign o_buf_release = state_q == RELEASE;
    assign o_frame_done  = state_q == RELEASE;
    assign o_busy        = state_q != IDLE;
endmodule

// File: tb/tb_fc_input_sequencer.sv
// tb_fc_input_sequencer: scoreboarded frame runs from a vector table plus abort/reset/back-to-back sequences.
module tb_fc_input_sequencer;
    localparam int NE = 225;
    localparam int NN = 10;
    localparam int DW = 22;

    typedef struct packed {
        logic signed [DW-1:0] d;
        logic [11:0]          wa;
        logic                 f;
        logic                 l;
        logic [3:0]           n;
    } beat_t;

    typedef struct {
        int pct;
        int dly;
        bit pat;
        bit spur;
        int exp_beats;
        int exp_firsts;
        int exp_rels;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0;
    logic i_buffer_full = 1'b0, i_mac_ready = 1'b0, i_acc_done = 1'b0, i_abort = 1'b0;
    logic [7:0] o_rd_addr;
    logic signed [DW-1:0] i_rd_data, o_mac_data;
    logic o_mac_valid, o_mac_first, o_mac_last, o_buf_release, o_busy, o_frame_done;
    logic [11:0] o_w_addr;
    logic [3:0] o_neuron_idx;

    int total = 0, bad = 0, beats = 0, firsts = 0, rels = 0, cyc = 0, done_cyc = -1;
    int acd = 0, acc_dly = 3;
    bit last_hs = 0, sb_on = 0, pat = 0;
    beat_t sbq[$];

    fc_input_sequencer #(.NUM_ELEMS(NE), .NUM_NEURONS(NN), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .i_buffer_full(i_buffer_full), .o_rd_addr(o_rd_addr),
        .i_rd_data(i_rd_data), .o_mac_valid(o_mac_valid), .i_mac_ready(i_mac_ready),
        .o_mac_data(o_mac_data), .o_w_addr(o_w_addr), .o_mac_first(o_mac_first),
        .o_mac_last(o_mac_last), .o_neuron_idx(o_neuron_idx), .i_acc_done(i_acc_done),
        .i_abort(i_abort), .o_buf_release(o_buf_release), .o_busy(o_busy),
        .o_frame_done(o_frame_done)
    );

    assign i_rd_data = pat ? DW'(1000000 - 9000 * int'(o_rd_addr)) : DW'(o_rd_addr);

    always #5 clk = ~clk;

    function automatic beat_t mk(int n, int e);
        beat_t b;
        b.d  = pat ? DW'(1000000 - 9000 * e) : DW'(e);
        b.wa = 12'(n * NE + e);
        b.f  = e == 0;
        b.l  = e == NE - 1;
        b.n  = 4'(n);
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // MAC model: acc_done arrives acc_dly cycles after the last beat's handshake
    task automatic tick();
        @(posedge clk);
        #1;
        i_acc_done = 1'b0;
        if (last_hs) begin
            last_hs = 0;
            acd = acc_dly;
        end
        if (acd > 0) begin
            acd--;
            i_acc_done = acd == 0;
        end
    endtask

    task automatic run_frame(input int pct, input bit spur, input int limit);
        bit started = 0, ok = 0;
        int r0 = rels;
        for (int n = 0; n < NN; n++)
            for (int e = 0; e < NE; e++) sbq.push_back(mk(n, e));
        i_buffer_full = 1'b1;
        for (int c = 0; c < limit; c++) begin
            tick();
            if (o_busy) started = 1;
            if (started && !o_busy && rels != r0) begin
                ok = 1;
                break;
            end
            i_mac_ready   = $urandom_range(99) < pct;
            i_buffer_full = !started || (spur && acd > 0);
            if (spur && o_mac_valid) i_acc_done = 1'($urandom_range(1));
        end
        i_acc_done = 1'b0;
        i_buffer_full = 1'b0;
        chk("frame_timeout", 64'(ok), 64'd1);
    endtask

    task automatic clean_abort();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        tick();
        acd = 0;
        last_hs = 0;
        i_acc_done = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        bit stall_prev = 0;
        beat_t held, cur, exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
                continue;
            end
            cur = {o_mac_data, o_w_addr, o_mac_first, o_mac_last, o_neuron_idx};
            if (stall_prev) chk("stall_hold", {23'd0, o_mac_valid, cur}, {23'd0, 1'b1, held});
            if (o_mac_valid && i_mac_ready) begin
                if (o_mac_last) last_hs = 1;
                if (sb_on) begin
                    beats++;
                    firsts += int'(o_mac_first);
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_extra: got beat %0h want none", cur);
                    end else begin
                        exp = sbq.pop_front();
                        chk("beat", 64'(cur), 64'(exp));
                    end
                end
            end
            if (o_buf_release) rels++;
            if (o_frame_done) done_cyc = cyc;
            stall_prev = o_mac_valid && !i_mac_ready && !i_abort;
            held = cur;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end want end");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        int r0, diff;
        bit found;
        vecs[0] = '{100, 3, 0, 0, NN * NE, NN, 1};
        vecs[1] = '{50, 3, 0, 0, NN * NE, NN, 1};
        vecs[2] = '{30, 1, 1, 1, NN * NE, NN, 1};
        vecs[3] = '{70, 5, 1, 1, NN * NE, NN, 1};

        #2 rst = 1'b1;
        #1 chk("reset_zero", 64'({o_mac_valid, o_mac_first, o_mac_last, o_buf_release, o_frame_done,
                                   o_busy, o_mac_data, o_w_addr, o_neuron_idx, o_rd_addr}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            pat = vecs[v].pat;
            acc_dly = vecs[v].dly;
            sb_on = 1;
            beats = 0;
            firsts = 0;
            r0 = rels;
            run_frame(vecs[v].pct, vecs[v].spur, 20000);
            sb_on = 0;
            chk("beats", 64'(beats), 64'(vecs[v].exp_beats));
            chk("firsts", 64'(firsts), 64'(vecs[v].exp_firsts));
            chk("releases", 64'(rels - r0), 64'(vecs[v].exp_rels));
            chk("sb_left", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end

        // abort at neuron 3, element 100, coinciding with a handshake
        pat = 0;
        acc_dly = 3;
        i_mac_ready = 1'b1;
        i_buffer_full = 1'b1;
        tick();
        i_buffer_full = 1'b0;
        found = 0;
        for (int c = 0; c < 5000; c++) begin
            if (o_mac_valid && o_w_addr == 12'd775) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("abort_reach", 64'(found), 64'd1);
        r0 = rels;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_valid", 64'(o_mac_valid), 64'd0);
        chk("abort_release", 64'({o_buf_release, o_frame_done, o_busy}), 64'b111);
        tick();
        chk("abort_idle", 64'({o_buf_release, o_busy}), 64'd0);
        chk("abort_one_rel", 64'(rels - r0), 64'd1);
        acd = 0;
        last_hs = 0;
        i_acc_done = 1'b0;
        i_buffer_full = 1'b1;
        tick();
        i_buffer_full = 1'b0;
        chk("abort_restart", 64'({o_mac_valid, o_mac_first, o_neuron_idx, o_w_addr}), {47'd0, 1'b1, 1'b1, 4'd0, 12'd0});
        clean_abort();

        // asynchronous reset in the middle of neuron 5
        i_buffer_full = 1'b1;
        tick();
        i_buffer_full = 1'b0;
        found = 0;
        for (int c = 0; c < 5000; c++) begin
            if (o_mac_valid && o_neuron_idx == 4'd5) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("rst_reach", 64'(found), 64'd1);
        r0 = rels;
        #2 rst = 1'b1;
        #1 chk("rst_async_zero", 64'({o_mac_valid, o_mac_first, o_mac_last, o_buf_release, o_frame_done,
                                      o_busy, o_mac_data, o_w_addr, o_neuron_idx, o_rd_addr}), 64'd0);
        acd = 0;
        last_hs = 0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("rst_no_release", 64'(rels - r0), 64'd0);
        chk("rst_idle", 64'(o_busy), 64'd0);
        i_buffer_full = 1'b1;
        tick();
        i_buffer_full = 1'b0;
        chk("rst_restart", 64'({o_mac_valid, o_neuron_idx, o_w_addr}), {47'd0, 1'b1, 4'd0, 12'd0});
        clean_abort();

        // back-to-back frames with i_buffer_full held high
        acc_dly = 2;
        done_cyc = -1;
        i_buffer_full = 1'b1;
        for (int c = 0; c < 5000 && done_cyc < 0; c++) tick();
        chk("b2b_done_seen", 64'(done_cyc >= 0), 64'd1);
        found = 0;
        for (int c = 0; c < 10; c++) begin
            if (o_mac_valid) begin
                found = 1;
                break;
            end
            tick();
        end
        diff = cyc - done_cyc;
        chk("b2b_gap", 64'(found ? diff : -1), 64'd2);
        chk("b2b_first", 64'({o_mac_first, o_w_addr}), {51'd0, 1'b1, 12'd0});
        i_buffer_full = 1'b0;
        clean_abort();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
